// File: rtl/spi_arb_pkg.sv
// Shared state encoding, default sizing and requester indices for the SPI configuration arbiter.
package spi_arb_pkg;

  localparam int NREQ_DEF    = 3;
  localparam int DW_DEF      = 24;
  localparam int GAP_CYC_DEF = 4;
  localparam int TMO_CYC_DEF = 4096;

  localparam int REQ_PLL = 0;
  localparam int REQ_ATT = 1;
  localparam int REQ_DAC = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GUARD
  } arb_state_t;

endpackage

// File: rtl/spi_cfg_arbiter_if.sv
// Requester and SPI-master signals of the configuration arbiter.
// SPI_ARB_READBACK_EN adds the readback word rdData.
interface spi_cfg_arbiter_if
  import spi_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
);
  logic [NREQ-1:0]    reqValid;
  logic [NREQ*DW-1:0] reqData;
  logic [NREQ-1:0]    reqReady;
  logic [NREQ-1:0]    reqDone;
  logic               spiWrEn;
  logic [DW-1:0]      spiData;
  logic               spiRdy;
  logic [DW-1:0]      spiDatBack;
  logic [NREQ-1:0]    csN;
  logic               busy;
  logic               tmoErr;
`ifdef SPI_ARB_READBACK_EN
  logic [DW-1:0]      rdData;

  modport slave (
    input  reqValid, reqData, spiRdy, spiDatBack,
    output reqReady, reqDone, spiWrEn, spiData, csN, busy, tmoErr, rdData
  );
  modport master (
    output reqValid, reqData, spiRdy, spiDatBack,
    input  reqReady, reqDone, spiWrEn, spiData, csN, busy, tmoErr, rdData
  );
`else
  modport slave (
    input  reqValid, reqData, spiRdy, spiDatBack,
    output reqReady, reqDone, spiWrEn, spiData, csN, busy, tmoErr
  );
  modport master (
    output reqValid, reqData, spiRdy, spiDatBack,
    input  reqReady, reqDone, spiWrEn, spiData, csN, busy, tmoErr
  );
`endif
endinterface

// File: rtl/spi_rr_pick.sv
// Combinational round-robin pick: first set reqValid at or after ptr, wrapping at NREQ.
module spi_rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] reqValid,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   winner,
  output logic            anyValid
);

  // Scan offsets from far to near so the nearest requester overwrites the rest.
  always_comb begin
    winner   = '0;
    anyValid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (reqValid[i] && (i == ((int'(ptr) + k) % NREQ))) begin
          winner   = PW'(i);
          anyValid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_cfg_arbiter.sv
// Round-robin arbiter serialising register writes from NREQ requesters onto one SPI master.
// Define SPI_ARB_READBACK_EN to add rdData, the byte-reversed word shifted back in.
module spi_cfg_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int DW      = DW_DEF,
  parameter int GAP_CYC = GAP_CYC_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input logic              clk,
  input logic              asyncRst,
  spi_cfg_arbiter_if.slave arb
);
  localparam int PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_MAX = (TMO_CYC > GAP_CYC) ? TMO_CYC : GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  function automatic logic [DW-1:0] byte_rev(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = '0;
    for (int b = 0; b < DW / 8; b++) r[b*8 +: 8] = d[DW-8-b*8 +: 8];
    return r;
  endfunction

  arb_state_t      r_state, w_state_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic [PW-1:0]   r_ptr, r_win, w_pick, w_ptr_nx;
  logic            w_any, w_grant, w_finish, w_tmo;
  logic [NREQ-1:0] w_pick_oh, w_win_oh;
  logic [NREQ-1:0] r_reqReady, r_reqDone, r_csN;
  logic            r_spiWrEn, r_tmoErr;
  logic [DW-1:0]   r_spiData;

  spi_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .reqValid (arb.reqValid),
    .ptr      (r_ptr),
    .winner   (w_pick),
    .anyValid (w_any)
  );

  assign w_pick_oh = NREQ'(1) << w_pick;
  assign w_win_oh  = NREQ'(1) << r_win;
  assign w_ptr_nx  = (w_pick == PW'(NREQ - 1)) ? '0 : w_pick + PW'(1);

  always_ff @(posedge clk or posedge asyncRst) begin
    if (asyncRst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // r_cnt times the SHIFT timeout and the GUARD gap; SHIFT ignores spiRdy while r_cnt is 0.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_grant    = 1'b0;
    w_finish   = 1'b0;
    w_tmo      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nx = '0;
        if (w_any && arb.spiRdy) begin
          w_state_nx = ST_LOAD;
          w_grant    = 1'b1;
        end
      end
      ST_LOAD: begin
        w_state_nx = ST_SHIFT;
        w_cnt_nx   = '0;
      end
      ST_SHIFT: begin
        if ((r_cnt != '0) && arb.spiRdy) begin
          w_state_nx = ST_GUARD;
          w_finish   = 1'b1;
          w_cnt_nx   = '0;
        end else if (r_cnt == CW'(TMO_CYC - 1)) begin
          w_state_nx = ST_GUARD;
          w_finish   = 1'b1;
          w_tmo      = 1'b1;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      ST_GUARD: begin
        if (r_cnt == CW'(GAP_CYC - 1)) begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // All outputs are registered; spiWrEn and the chip select follow LOAD by one cycle.
  always_ff @(posedge clk or posedge asyncRst) begin
    if (asyncRst) begin
      r_ptr      <= '0;
      r_win      <= '0;
      r_reqReady <= '0;
      r_reqDone  <= '0;
      r_csN      <= '1;
      r_spiWrEn  <= 1'b0;
      r_tmoErr   <= 1'b0;
      r_spiData  <= '0;
    end else begin
      r_reqReady <= '0;
      r_reqDone  <= '0;
      r_spiWrEn  <= 1'b0;
      if (w_grant) begin
        r_reqReady <= w_pick_oh;
        r_win      <= w_pick;
        r_ptr      <= w_ptr_nx;
        r_spiData  <= byte_rev(arb.reqData[w_pick*DW +: DW]);
      end
      if (r_state == ST_LOAD) begin
        r_spiWrEn <= 1'b1;
        r_csN     <= ~w_win_oh;
      end
      if (w_finish) begin
        r_csN     <= '1;
        r_reqDone <= w_win_oh;
      end
      if (w_tmo) r_tmoErr <= 1'b1;
    end
  end

  assign arb.reqReady = r_reqReady;
  assign arb.reqDone  = r_reqDone;
  assign arb.csN      = r_csN;
  assign arb.spiWrEn  = r_spiWrEn;
  assign arb.spiData  = r_spiData;
  assign arb.tmoErr   = r_tmoErr;
  assign arb.busy     = (r_state != ST_IDLE);

`ifdef SPI_ARB_READBACK_EN
  logic [DW-1:0] r_rdData;

  always_ff @(posedge clk or posedge asyncRst) begin
    if (asyncRst) r_rdData <= '0;
    else if (w_finish) r_rdData <= byte_rev(arb.spiDatBack);
  end

  assign arb.rdData = r_rdData;
`else
  logic w_unused_datback;
  assign w_unused_datback = ^arb.spiDatBack;
`endif

endmodule

// File: tb/tb_spi_cfg_arbiter.sv
// Scoreboard bench for spi_cfg_arbiter: directed requests, round robin, timeout, withdrawal, reset.
module tb_spi_cfg_arbiter;
  import spi_arb_pkg::*;

  localparam int NREQ = 3;
  localparam int DW   = 24;
  localparam int GAP  = 4;
  localparam int TMO  = 4096;

  logic clk = 1'b0;
  logic asyncRst;
  always #5 clk = ~clk;

  spi_cfg_arbiter_if #(.NREQ(NREQ), .DW(DW)) arb();

  spi_cfg_arbiter #(.NREQ(NREQ), .DW(DW), .GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
    .clk      (clk),
    .asyncRst (asyncRst),
    .arb      (arb)
  );

  typedef struct {
    int            idx;
    logic [DW-1:0] dat;
    int            lat;
    logic          tmo;
    bit            chk_rd;
    logic [DW-1:0] rd;
    longint        tg;
    longint        tw;
  } exp_t;

  exp_t q_g[$];
  exp_t q_w[$];
  exp_t q_d[$];

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  int     xfer_len  = 3;
  bit     stuck     = 1'b0;
  bit     auto_drop = 1'b1;
  logic   tmo_exp   = 1'b0;
  logic [DW-1:0] back_val = 24'hA1B2C3;
  logic [DW-1:0] src     [NREQ] = '{24'h300009, 24'h123456, 24'hA0B0C0};
  logic [DW-1:0] exp_rev [NREQ] = '{24'h090030, 24'h563412, 24'hC0B0A0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input int idx);
    exp_t e;
    e.idx    = idx;
    e.dat    = exp_rev[idx];
    e.lat    = stuck ? TMO : 2 + xfer_len;
    e.tmo    = stuck ? 1'b1 : tmo_exp;
    e.chk_rd = !stuck;
    e.rd     = 24'hC3B2A1;
    e.tg     = 0;
    e.tw     = 0;
    q_g.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((arb.busy !== 1'b0 || q_g.size() != 0 || q_w.size() != 0 || q_d.size() != 0 ||
            arb.reqValid != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", n < budget, 1);
  endtask

  task automatic wait_grants(input int n, input int budget);
    int seen, c;
    seen = 0;
    c = 0;
    while (seen < n && c < budget) begin
      @(negedge clk);
      c++;
      if (arb.reqReady != 0) seen++;
    end
    chk("grants_within_budget", seen, n);
  endtask

  // Requesters drop their request once granted, unless auto_drop is cleared.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_drop) arb.reqValid = arb.reqValid & ~arb.reqReady;
    end
  end

  // SPI master model: busy for xfer_len cycles after the cycle following spiWrEn, or until stuck clears.
  initial begin
    arb.spiRdy     = 1'b1;
    arb.spiDatBack = '0;
    forever begin
      @(negedge clk);
      if (arb.spiWrEn === 1'b1) begin
        @(negedge clk);
        arb.spiRdy = 1'b0;
        if (stuck) begin
          while (stuck) @(negedge clk);
        end else begin
          repeat (xfer_len) @(negedge clk);
        end
        arb.spiDatBack = back_val;
        arb.spiRdy     = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each grant, write strobe and completion.
  initial begin
    exp_t e;
    int   hi_run;
    bit   had_done;
    logic [NREQ-1:0] m;
    hi_run   = 0;
    had_done = 1'b0;
    forever begin
      @(negedge clk);
      if (asyncRst === 1'b0) begin
        chk("one_ready", $countones(arb.reqReady) <= 1, 1);
        chk("one_done", $countones(arb.reqDone) <= 1, 1);
        chk("one_cs_low", $countones(~arb.csN) <= 1, 1);

        if (arb.reqReady != 0) begin
          if (q_g.size() == 0) chk("unexpected_grant", arb.reqReady, 0);
          else begin
            e = q_g.pop_front();
            chk("grant_idx", arb.reqReady, 64'(1) << e.idx);
            chk("busy_at_grant", arb.busy, 1);
            e.tg = cyc;
            q_w.push_back(e);
          end
        end

        if (arb.spiWrEn === 1'b1) begin
          if (q_w.size() == 0) chk("unexpected_wr", arb.spiWrEn, 0);
          else begin
            e = q_w.pop_front();
            m = ~(NREQ'(1) << e.idx);
            chk("spi_data", arb.spiData, e.dat);
            chk("cs_at_wr", arb.csN, m);
            chk("grant_to_wr", cyc - e.tg, 1);
            e.tw = cyc;
            q_d.push_back(e);
          end
        end

        if (arb.reqDone != 0) begin
          if (q_d.size() == 0) chk("unexpected_done", arb.reqDone, 0);
          else begin
            e = q_d.pop_front();
            chk("done_idx", arb.reqDone, 64'(1) << e.idx);
            chk("wr_to_done", cyc - e.tw, e.lat);
            chk("tmo_flag", arb.tmoErr, e.tmo);
            chk("cs_high_at_done", arb.csN, 3'b111);
`ifdef SPI_ARB_READBACK_EN
            if (e.chk_rd) chk("rd_data", arb.rdData, e.rd);
`endif
            had_done = 1'b1;
          end
        end else if (q_d.size() > 0) begin
          m = ~(NREQ'(1) << q_d[0].idx);
          chk("cs_hold", arb.csN, m);
        end

        if (arb.csN == 3'b111) hi_run++;
        else begin
          if (hi_run > 0 && had_done) chk("guard_gap", hi_run >= GAP, 1);
          hi_run = 0;
        end
      end
    end
  end

  initial begin
    int n;
    asyncRst     = 1'b1;
    arb.reqValid = '0;
    arb.reqData  = {src[2], src[1], src[0]};
    repeat (3) @(negedge clk);
    chk("rst_csN", arb.csN, 3'b111);
    chk("rst_spiWrEn", arb.spiWrEn, 0);
    chk("rst_reqReady", arb.reqReady, 0);
    chk("rst_reqDone", arb.reqDone, 0);
    chk("rst_busy", arb.busy, 0);
    chk("rst_tmoErr", arb.tmoErr, 0);
    chk("rst_spiData", arb.spiData, 0);
    asyncRst = 1'b0;
    repeat (2) @(negedge clk);

    // Round robin with all requests held from reset pointer 0.
    xfer_len  = 2;
    auto_drop = 1'b0;
    issue(REQ_PLL); issue(REQ_ATT); issue(REQ_DAC); issue(REQ_PLL);
    arb.reqValid = 3'b111;
    wait_grants(4, 300);
    arb.reqValid = '0;
    auto_drop    = 1'b1;
    wait_idle(300);

    // Single request, request-to-grant latency.
    xfer_len = 3;
    issue(REQ_PLL);
    arb.reqValid = 3'b001;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (arb.reqReady == 0 && n < 20);
    chk("req_to_grant", n, 1);
    wait_idle(200);

    // Withdrawal: requester 2 pulses while busy and drops before IDLE.
    xfer_len = 6;
    issue(REQ_PLL);
    arb.reqValid = 3'b001;
    wait_grants(1, 20);
    @(negedge clk);
    arb.reqValid[2] = 1'b1;
    repeat (3) @(negedge clk);
    arb.reqValid[2] = 1'b0;
    wait_idle(200);
    repeat (20) @(negedge clk);

    // Timeout: master never becomes ready again.
    stuck = 1'b1;
    issue(REQ_ATT);
    arb.reqValid = 3'b010;
    wait_idle(TMO + 300);
    chk("tmo_sticky_after", arb.tmoErr, 1);
    chk("busy_after_tmo", arb.busy, 0);
    stuck   = 1'b0;
    tmo_exp = 1'b1;
    repeat (3) @(negedge clk);

    // Normal transfer after timeout keeps tmoErr set; ptr is 2 here.
    xfer_len = 2;
    issue(REQ_DAC);
    arb.reqValid = 3'b100;
    wait_idle(200);

    // Reset in SHIFT, after a grant to 0 moved ptr to 1.
    xfer_len = 8;
    issue(REQ_PLL);
    arb.reqValid = 3'b001;
    n = 0;
    while (arb.spiWrEn !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wr_before_reset", arb.spiWrEn, 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    asyncRst = 1'b1;
    q_w.delete();
    q_d.delete();
    #1;
    chk("midrst_csN", arb.csN, 3'b111);
    chk("midrst_busy", arb.busy, 0);
    chk("midrst_spiWrEn", arb.spiWrEn, 0);
    chk("midrst_reqDone", arb.reqDone, 0);
    chk("midrst_tmoErr", arb.tmoErr, 0);
    chk("midrst_spiData", arb.spiData, 0);
    @(negedge clk);
    asyncRst = 1'b0;
    tmo_exp  = 1'b0;
    @(negedge clk);

    // ptr back at 0: 011 grants 0 first, then 1.
    xfer_len = 2;
    issue(REQ_PLL); issue(REQ_ATT);
    arb.reqValid = 3'b011;
    wait_idle(300);

    issue(REQ_ATT);
    arb.reqValid = 3'b010;
    wait_idle(200);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: still running at time %0t, limit 1000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_cfg_arbiter.md
SPI_CFG_ARBITER -- requirements
Module: spi_cfg_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3: number of configuration requesters (PLL init, attenuator, DAC).
REQ-002 SHALL have parameter DW, default 24: SPI word width in bits; must be a multiple of 8.
REQ-003 SHALL have parameter GAP_CYC, default 4: guard cycles with all chip selects high after each word.
REQ-004 SHALL have parameter TMO_CYC, default 4096: maximum cycles to wait for spiRdy.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port asyncRst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port reqValid, input, NREQ bits: per-requester transfer request.
REQ-008 SHALL have port reqData, input, NREQ*DW bits: per-requester register word, MSB first.
REQ-009 SHALL have port reqReady, output, NREQ bits: one-cycle grant pulse; data is captured that cycle.
REQ-010 SHALL have port reqDone, output, NREQ bits: one-cycle completion pulse.
REQ-011 SHALL have port spiWrEn, output, 1 bit: write strobe to the SPI master.
REQ-012 SHALL have port spiData, output, DW bits: the captured word, byte-reversed.
REQ-013 SHALL have port spiRdy, input, 1 bit: the SPI master is idle.
REQ-014 SHALL have port spiDatBack, input, DW bits: word shifted in by the SPI master.
REQ-015 SHALL have port csN, output, NREQ bits: active-low chip select/LE per device.
REQ-016 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-017 SHALL have port tmoErr, output, 1 bit: sticky timeout flag.

Function
REQ-018 SHALL implement the FSM states IDLE, LOAD, SHIFT, GUARD.
- IDLE -> LOAD when any reqValid=1 and spiRdy=1: pulse reqReady[winner], latch the data and the winner index.
- LOAD: spiWrEn=1 for exactly one cycle; csN[winner]=0 from this cycle.
- LOAD -> SHIFT unconditionally.
- SHIFT: ignore spiRdy for its first cycle, then wait for spiRdy=1.
- SHIFT -> GUARD on spiRdy=1: csN all high, reqDone[winner] pulses on GUARD entry.
- GUARD -> IDLE after GAP_CYC cycles.
REQ-019 SHALL pick the winner round-robin: the first set reqValid at or after pointer ptr; ptr becomes winner+1 mod NREQ at grant.
REQ-020 SHALL present spiData with byte order reversed relative to the reqData slice (lowest byte sent first by the master), held stable from LOAD until the next grant.
REQ-021 SHALL ignore reqValid deassertion after grant; a request dropped before grant produces no transfer.
REQ-022 SHALL, when SHIFT lasts TMO_CYC cycles without spiRdy, set tmoErr, enter GUARD and still pulse reqDone; tmoErr is cleared only by reset.
REQ-023 SHALL allow at most one reqReady bit and at most one reqDone bit per cycle, and at most one csN bit low.
REQ-024 SHALL have no combinational path from inputs to outputs; the minimum request-to-spiWrEn latency is 2 cycles.

Reset
REQ-025 SHALL, on asyncRst=1 (including mid-transfer), immediately force: state=IDLE, ptr=0, csN all ones, spiWrEn=0, reqReady=0, reqDone=0, busy=0, tmoErr=0, spiData=0.

Configuration
REQ-026 SHALL, with SPI_ARB_READBACK_EN defined, add the output port rdData (DW bits): spiDatBack, byte-reversed, captured on SHIFT->GUARD and valid with reqDone.
REQ-027 SHALL, without SPI_ARB_READBACK_EN, omit rdData and ignore spiDatBack.

Structure
REQ-028 SHALL place the state encoding typedef, default NREQ/DW/GAP_CYC/TMO_CYC and the requester index constants in the shared package spi_arb_pkg.
REQ-029 SHALL implement winner selection in the sub-module spi_rr_pick: combinational, with inputs reqValid and ptr and outputs winner and anyValid.

Verification
REQ-030 SHALL cover a single request: reqValid=001, reqData[0]=0x300009 -> reqReady=001 at T, spiWrEn at T+1, spiData=0x090030, csN=110 until spiRdy, then reqDone=001.
REQ-031 SHALL cover a round-robin rotation: reqValid=111 held -> grant order 0,1,2,0; every grant is followed by ≥GAP_CYC cycles with csN=111.
REQ-032 SHALL cover the timeout: spiRdy held 0 after LOAD -> tmoErr=1 after 4096 cycles, reqDone pulses, FSM returns to IDLE.
REQ-033 SHALL cover reset mid-transfer: asyncRst asserted in SHIFT -> csN=111, busy=0 in the same cycle; after release, reqValid=010 -> grant 1.
REQ-034 SHALL cover a request withdrawal: reqValid[2] pulsed while busy and dropped before IDLE -> no grant to requester 2.
REQ-035 SHALL cover readback, with SPI_ARB_READBACK_EN: spiDatBack=0xA1B2C3 -> rdData=0xC3B2A1 during the reqDone cycle.
